pc_ctrl: RTL

Parametrised program-counter controller; successor to the single-width PC register. It holds the fetch address, resolves next-PC for sequential, jump and branch operations, and adds three things: correct unsigned branch compares, misaligned-target trapping, and a BOOT/RUN/HALT state machine. It also exposes a retired-instruction counter. It sits between the control unit/ALU and instruction memory.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pc_ctrl_if.sv | 34 +++
 rtl/pc_ctrl_branch_resolve.sv | 46 ++++
 rtl/pc_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: decoded control ops, PC controller states and the fetch step size.
package cpu_pkg;

  typedef enum logic [3:0] {
    CU_NOP   = 4'd0,
    CU_ALU   = 4'd1,
    CU_LOAD  = 4'd2,
    CU_STORE = 4'd3,
    CU_JAL   = 4'd4,
    CU_JALR  = 4'd5,
    CU_BEQ   = 4'd6,
    CU_BNE   = 4'd7,
    CU_BLT   = 4'd8,
    CU_BGE   = 4'd9,
    CU_BLTU  = 4'd10,
    CU_BGEU  = 4'd11,
    CU_HALT  = 4'd12
  } cu_op_t;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_ctrl_if.sv
// Control-unit <-> PC controller bundle; master is the control unit/ALU side, slave is pc_ctrl.
interface pc_ctrl_if
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic              iready;
  cu_op_t            cuOP;
  logic [XLEN-1:0]   rs1Read;
  logic [XLEN-1:0]   signExtend;
  logic              Zero;
  logic              ALUneg;
  logic              ALUltu;
  logic [XLEN-1:0]   trap_vec;
  logic              resume;
  logic [XLEN-1:0]   PCaddr;
  logic [XLEN-1:0]   link_pc;
  logic              fetch_en;
  logic              halted;
  logic              trap;
  logic [XLEN-1:0]   epc;
  logic [CNT_W-1:0]  instret;

  modport master (
    output iready, cuOP, rs1Read, signExtend, Zero, ALUneg, ALUltu, trap_vec, resume,
    input  PCaddr, link_pc, fetch_en, halted, trap, epc, instret
  );

  modport slave (
    input  iready, cuOP, rs1Read, signExtend, Zero, ALUneg, ALUltu, trap_vec, resume,
    output PCaddr, link_pc, fetch_en, halted, trap, epc, instret
  );
endinterface

// File: rtl/pc_ctrl_branch_resolve.sv
// Combinational jump/branch resolution: taken flag, redirect target and misalignment.
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  cu_op_t          cuOP,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] rs1Read,
  input  logic [XLEN-1:0] signExtend,
  input  logic            Zero,
  input  logic            ALUneg,
  input  logic            ALUltu,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] w_rel;
  logic [XLEN-1:0] w_jalr;

  assign w_rel  = PC + signExtend;
  assign w_jalr = (rs1Read + signExtend) & ~XLEN'(1);

  always_comb begin
    taken  = 1'b0;
    target = w_rel;
    case (cuOP)
      CU_JAL:  taken = 1'b1;
      CU_JALR: begin
        taken  = 1'b1;
        target = w_jalr;
      end
      CU_BEQ:  taken = Zero;
      CU_BNE:  taken = !Zero;
      CU_BLT:  taken = ALUneg;
      CU_BGE:  taken = !ALUneg;
      CU_BLTU: taken = ALUltu;
      CU_BGEU: taken = !ALUltu;
      default: taken = 1'b0;
    endcase
    // JALR target bit 0 is already cleared, so one test covers both alignment rules.
    misaligned = taken && (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_ctrl.sv
// PC controller: BOOT/RUN/HALT FSM, PC/epc/instret registers, 1-cycle redirect latency.
// Stalls (holds everything) while iready is low in RUN; HALT ignores all but resume.
module pc_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN   = 32,
  parameter logic [XLEN-1:0] INITPC = '0,
  parameter int unsigned     CNT_W  = 32
) (
  input  logic     clk,
  input  logic     nRST,
  pc_ctrl_if.slave bus
);

  pc_state_t        r_state;
  pc_state_t        w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_nxt;
  logic [XLEN-1:0]  r_epc;
  logic [XLEN-1:0]  w_epc_nxt;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] w_instret_nxt;
  logic             r_trap;
  logic             w_trap_nxt;

  logic             w_taken;
  logic [XLEN-1:0]  w_target;
  logic             w_misaligned;
  logic [XLEN-1:0]  w_seq_pc;
  logic [XLEN-1:0]  w_trap_vec;

  branch_resolve #(.XLEN(XLEN)) u_branch_resolve (
    .cuOP       (bus.cuOP),
    .PC         (r_pc),
    .rs1Read    (bus.rs1Read),
    .signExtend (bus.signExtend),
    .Zero       (bus.Zero),
    .ALUneg     (bus.ALUneg),
    .ALUltu     (bus.ALUltu),
    .taken      (w_taken),
    .target     (w_target),
    .misaligned (w_misaligned)
  );

  assign w_seq_pc   = r_pc + XLEN'(PC_STEP);
  assign w_trap_vec = bus.trap_vec & ~XLEN'(3);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= PC_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_pc      <= INITPC;
      r_epc     <= '0;
      r_instret <= '0;
      r_trap    <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_epc     <= w_epc_nxt;
      r_instret <= w_instret_nxt;
      r_trap    <= w_trap_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_epc_nxt     = r_epc;
    w_instret_nxt = r_instret;
    w_trap_nxt    = 1'b0;
    case (r_state)
      PC_BOOT: w_state_nxt = PC_RUN;
      PC_RUN: begin
        if (bus.iready) begin
          // A faulting redirect does not retire; the handler starts at trap_vec.
          if (w_misaligned) begin
            w_pc_nxt   = w_trap_vec;
            w_epc_nxt  = r_pc;
            w_trap_nxt = 1'b1;
          end else begin
            w_pc_nxt      = w_taken ? w_target : w_seq_pc;
            w_instret_nxt = r_instret + CNT_W'(1);
            if (bus.cuOP == CU_HALT) begin
              w_state_nxt = PC_HALT;
            end
          end
        end
      end
      PC_HALT: begin
        if (bus.resume) begin
          w_state_nxt = PC_RUN;
        end
      end
      default: w_state_nxt = PC_BOOT;
    endcase
  end

  assign bus.PCaddr   = r_pc;
  assign bus.link_pc  = w_seq_pc;
  assign bus.fetch_en = (r_state == PC_RUN);
  assign bus.halted   = (r_state == PC_HALT);
  assign bus.trap     = r_trap;
  assign bus.epc      = r_epc;
  assign bus.instret  = r_instret;

endmodule
